// File: rtl/guia06_pkg.sv
// Shared types and constants for the truth-table sweeper.
package guia06_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam int N_IN_DEF   = 4;
  localparam int SETTLE_DEF = 1;

  // Reference function: minterms 2, 9, 13 and 15.
  localparam logic [15:0] MASK_0608 = 16'hA204;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Loadable down-counter with zero flag; sets the hold time of each vector.
module settle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                       count <= '0;
    else if (load)                   count <= load_val;
    else if (dec && (count != '0))   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector into a combinational function, samples its output
// after a settle time and compares the measured truth table with a mask.
module truth_table_sweeper
  import guia06_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   truth_table,
  output logic                   match,
  output logic [N_IN-1:0]        first_err,
  output logic [N_IN:0]          err_count
);

  localparam int               TW        = 1 << N_IN;
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0]  IDX_LAST  = '1;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [TW-1:0]   exp_q;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            miss;
  logic [N_IN:0]   err_next;

  assign cnt_load = ((state == S_IDLE) && start) ||
                    ((state == S_SAMPLE) && (idx != IDX_LAST));
  assign cnt_dec  = (state == S_SETTLE);
  assign miss     = (dut_out != exp_q[idx]);
  assign err_next = err_count + (N_IN+1)'(miss);

  settle_counter #(.W(4)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (SETTLE_LD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      exp_q       <= '0;
      dut_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      match       <= 1'b0;
      first_err   <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx         <= '0;
            dut_in      <= '0;
            exp_q       <= expected;
            truth_table <= '0;
            err_count   <= '0;
            first_err   <= '0;
            match       <= 1'b0;
            busy        <= 1'b1;
            state       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_zero) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          truth_table[idx] <= dut_out;
          err_count        <= err_next;
          if (miss && (err_count == '0)) first_err <= idx;
          if (idx == IDX_LAST) begin
            // match is taken from the final update so it is valid alongside done
            match <= (err_next == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            idx    <= idx + 1'b1;
            dut_in <= idx + 1'b1;
            state  <= S_SETTLE;
          end
        end
        S_DONE: begin
          done   <= 1'b0;
          dut_in <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench: two sweepers (SETTLE=1 combinational, SETTLE=3 delayed).
module tb_truth_table_sweeper;
  import guia06_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // default instance, combinational function
  logic        start0;
  logic [15:0] exp0, fn0, tbl0;
  logic [3:0]  din0, ferr0;
  logic        s0, busy0, done0, match0;
  logic [4:0]  errc0;
  assign s0 = fn0[din0];

  truth_table_sweeper u0 (
    .clk(clk), .reset(reset), .start(start0), .expected(exp0), .dut_in(din0),
    .dut_out(s0), .busy(busy0), .done(done0), .truth_table(tbl0), .match(match0),
    .first_err(ferr0), .err_count(errc0)
  );

  // SETTLE=3 instance, function with one registered delay
  logic        start1;
  logic [15:0] exp1, fn1, tbl1;
  logic [3:0]  din1, ferr1;
  logic        s1, busy1, done1, match1;
  logic [4:0]  errc1;
  always_ff @(posedge clk) s1 <= fn1[din1];

  truth_table_sweeper #(.N_IN(4), .SETTLE(3)) u1 (
    .clk(clk), .reset(reset), .start(start1), .expected(exp1), .dut_in(din1),
    .dut_out(s1), .busy(busy1), .done(done1), .truth_table(tbl1), .match(match1),
    .first_err(ferr1), .err_count(errc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: measured table is the function itself; errors are differing minterms.
  function automatic void model(input logic [15:0] fn, input logic [15:0] ex,
                                output int ec, output int fe);
    logic [15:0] diff;
    diff = fn ^ ex;
    ec = $countones(diff);
    fe = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) fe = i;
  endfunction

  task automatic sweep(input int which, input logic [15:0] fn, input logic [15:0] ex,
                       input string tag);
    int ec, fe, dcyc, hold, lat;
    bit steps_ok;
    logic dn, bs;
    logic [3:0] di;
    model(fn, ex, ec, fe);
    hold = (which == 0) ? 2 : 4;
    lat  = 16 * hold;
    @(negedge clk);
    if (which == 0) begin fn0 = fn; exp0 = ex; start0 = 1'b1; end
    else            begin fn1 = fn; exp1 = ex; start1 = 1'b1; end
    @(posedge clk);
    dcyc = -1;
    steps_ok = 1'b1;
    for (int k = 0; k < 300 && dcyc < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin start0 = 1'b0; start1 = 1'b0; end
      dn = (which == 0) ? done0 : done1;
      bs = (which == 0) ? busy0 : busy1;
      di = (which == 0) ? din0  : din1;
      if (dn) dcyc = k;
      else if (k < lat && (di !== 4'(k / hold) || bs !== 1'b1)) steps_ok = 1'b0;
    end
    chk({tag, " steps"}, 32'(steps_ok), 32'd1);
    chk({tag, " latency"}, dcyc, lat);
    if (which == 0) begin
      chk({tag, " table"}, tbl0, fn);
      chk({tag, " match"}, match0, (ec == 0));
      chk({tag, " err_count"}, errc0, ec);
      chk({tag, " first_err"}, ferr0, fe);
      chk({tag, " busy@done"}, busy0, 0);
    end else begin
      chk({tag, " table"}, tbl1, fn);
      chk({tag, " match"}, match1, (ec == 0));
      chk({tag, " err_count"}, errc1, ec);
      chk({tag, " first_err"}, ferr1, fe);
      chk({tag, " busy@done"}, busy1, 0);
    end
    @(negedge clk);
    dn = (which == 0) ? done0 : done1;
    di = (which == 0) ? din0  : din1;
    chk({tag, " done_one_cycle"}, dn, 0);
    chk({tag, " din_back_to_0"}, di, 0);
  endtask

  initial begin
    int nd, d1, d2;
    logic [15:0] fn, ex;
    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0;
    fn0 = 16'h0; exp0 = 16'h0; fn1 = 16'h0; exp1 = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy0, 0);
    chk("rst done", done0, 0);
    chk("rst din", din0, 0);
    chk("rst table", tbl0, 0);
    chk("rst match", match0, 0);
    chk("rst first_err", ferr0, 0);
    chk("rst err_count", errc0, 0);
    chk("rst u1 busy", busy1, 0);
    reset = 1'b0;

    sweep(0, MASK_0608, 16'hA204, "exact");
    sweep(0, MASK_0608, 16'hA205, "one_err");
    sweep(0, MASK_0608, 16'h0000, "exp_zero");

    // Continuous start: IDLE re-accepts only every 34 cycles.
    @(negedge clk);
    fn0 = MASK_0608; exp0 = MASK_0608; start0 = 1'b1;
    nd = 0; d1 = -1; d2 = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done0) begin
        nd++;
        if (d1 < 0) d1 = k; else d2 = k;
      end
    end
    start0 = 1'b0;
    chk("hold done_count", nd, 2);
    chk("hold spacing", d2 - d1, 34);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a sweep
    @(negedge clk);
    fn0 = MASK_0608; exp0 = 16'h0000; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst busy", busy0, 0);
    chk("midrst din", din0, 0);
    chk("midrst table", tbl0, 0);
    chk("midrst err_count", errc0, 0);
    chk("midrst done", done0, 0);
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done0) nd++;
    end
    chk("midrst no_done", nd, 0);
    sweep(0, MASK_0608, MASK_0608, "after_rst");

    // Every minterm wrong: err_count reaches TW
    sweep(0, 16'h5A3C, ~16'h5A3C, "all_err");

    for (int r = 0; r < 6; r++) begin
      fn = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       ex = fn;
        1:       ex = fn ^ (16'h1 << $urandom_range(0, 15));
        default: ex = 16'($urandom);
      endcase
      sweep(0, fn, ex, $sformatf("rnd%0d", r));
    end

    sweep(1, MASK_0608, 16'hA204, "s3_exact");
    for (int r = 0; r < 2; r++) begin
      fn = 16'($urandom);
      ex = 16'($urandom);
      sweep(1, fn, ex, $sformatf("s3_rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that wraps a 4-input combinational function under test. It drives every input vector in ascending order into the function's inputs, samples the function's output after a programmable settle time, and assembles the measured truth table. It then compares the table against an expected minterm mask. It sits directly upstream of the function (it feeds w, x, y, z) and directly downstream of it (it consumes s), and replaces hand-written stimulus lists with a clocked, self-checking sweep.

## Interface
- N_IN, default 4, number of function inputs; legal 2..6; table width TW = 2**N_IN.
- SETTLE, default 1, cycles each vector is held before sampling; legal 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; one clock; all state and outputs take reset values on the next edge.
- start  in  1  request a sweep; sampled only in IDLE.
- expected  in  TW  expected minterm mask, bit i = expected output for vector i; latched on accepted start.
- dut_in  out  N_IN  vector driven to the function, MSB = w, LSB = z; registered.
- dut_out  in  1  function output s.
- busy  out  1  high from the edge accepting start until done.
- done  out  1  one-cycle pulse at sweep completion.
- table  out  TW  measured truth table, bit i = sampled s for vector i.
- match  out  1  table == latched expected; valid when done is high, held until next start.
- first_err  out  N_IN  lowest mismatching vector index; 0 if none.
- err_count  out  N_IN+1  number of mismatching vectors (0..TW).

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE with start=1:
  - idx<=0, dut_in<=0, settle counter<=SETTLE-1.
  - table, err_count, first_err <= 0; match <= 0; expected latched.
  - Go to SETTLE.
- IDLE with start=0: stay in IDLE.
- SETTLE: if counter==0 go SAMPLE, else decrement. dut_in holds idx.
- SAMPLE:
  - table[idx] <= dut_out.
  - If dut_out != exp[idx]: err_count++. If err_count was 0, first_err <= idx.
  - If idx == TW-1, go DONE. Otherwise idx++, dut_in <= idx+1, counter <= SETTLE-1, go SETTLE.
- DONE:
  - done=1 for one cycle; busy=0.
  - match <= (err_count==0); compute from the final SAMPLE update.
  - dut_in <= 0; go IDLE.
- start while busy: ignored, no queuing. start high in the DONE cycle is ignored. start high in the following IDLE cycle is accepted.
- Index wrap: idx never exceeds TW-1. No modular wrap occurs inside a sweep.
- err_count saturates naturally at TW; its width is sized to hold TW.
- Reset mid-sweep: sweep aborted, no done pulse, outputs take reset values.
- Reset values: dut_in=0, busy=0, done=0, table=0, match=0, first_err=0, err_count=0, state=IDLE.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in SETTLE, then 1 cycle in SAMPLE.
- dut_out is sampled at the SAMPLE edge, after dut_in has been stable at least SETTLE+1 edges.
- Start accepted at edge E0. DONE state, with done=1, is occupied from edge E0 + TW*(SETTLE+1).
- busy falls in the same cycle that done rises.
- Default N_IN=4, SETTLE=1: 32 cycles of sweep; done high 32 cycles after the start edge.
- Back-to-back sweeps: the minimum start-to-start spacing is TW*(SETTLE+1)+2 cycles.

## Structure
- Shared package guia06_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DONE);
  - the default constants N_IN_DEF=4 and SETTLE_DEF=1;
  - the mask constant MASK_0608 = 16'hA204, covering minterms 2, 9, 13 and 15.
- One sub-module is natural: settle_counter, a loadable down-counter with a zero flag. Everything else stays in the top.

## Test plan
- Default params with the minterm-2/9/13/15 function, expected=16'hA204, pulse start:
  - dut_in steps through 0..15, two cycles each;
  - done pulses once, 32 cycles after start;
  - table=16'hA204, match=1, err_count=0, first_err=0.
- Same function with expected=16'hA205:
  - table=16'hA204, match=0, err_count=1, first_err=0.
- Same function with expected=16'h0000:
  - err_count=4, first_err=2, match=0.
- Hold start high continuously for 80 cycles:
  - exactly two sweeps run, with done pulses 34 cycles apart;
  - no start is accepted while busy=1.
- Assert reset at cycle 10 of a sweep:
  - the next edge gives busy=0, dut_in=0, table=0, err_count=0;
  - no done pulse;
  - a fresh start then completes normally.
- SETTLE=3 with a function that has one cycle of extra registered delay:
  - table is still correct;
  - done arrives 64 cycles after start.
